// File: rtl/out_fm_tile_ctrl_pkg.sv
// Shared definitions for the output feature-map tile controller:
// state encoding and the sizing helpers used by the interface and the top.
package out_fm_tile_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_STORE   = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width that stays at least one bit wide, even for a single bank.
  function automatic int bank_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Words held by one bank: each bank stores Tn/Y output maps of Tr x Tc.
  function automatic int cap_words(input int tn, input int tr, input int tc, input int y);
    return (tn / y) * tr * tc;
  endfunction

  // Words in a whole tile, spread across all banks.
  function automatic int total_words(input int tn, input int tr, input int tc);
    return tn * tr * tc;
  endfunction

endpackage

// File: rtl/out_fm_tile_ctrl_if.sv
// Load stream, bank write/read port and store-side handshake of the
// tile controller. master = controller side, slave = datapath/environment.
interface out_fm_tile_ctrl_if #(
  parameter int DW = 32,
  parameter int Y  = 4
);
  import out_fm_tile_ctrl_pkg::*;

  localparam int BW = bank_w(Y);

  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] wr_data;
  logic [Y-1:0]  wr_ena;
  logic [Y-1:0]  rd_ena;
  logic          st_ready;
  logic          st_valid;
  logic [BW-1:0] st_bank;

  modport master (
    input  ld_data, ld_valid, st_ready,
    output ld_ready, wr_data, wr_ena, rd_ena, st_valid, st_bank
  );

  modport slave (
    output ld_data, ld_valid, st_ready,
    input  ld_ready, wr_data, wr_ena, rd_ena, st_valid, st_bank
  );

endinterface

// File: rtl/out_fm_tile_ctrl_counter.sv
// Wrapping word counter: counts 0..MAX on inc, returns to 0 after MAX,
// and is held at 0 while clr is high.
module out_fm_tile_ctrl_counter #(
  parameter int CW  = 16,
  parameter int MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // Count accepted words, wrapping at MAX so the value never exceeds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == CW'(MAX)) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/out_fm_tile_ctrl.sv
// Output feature-map tile controller: loads the out_fm banks, hands them to
// the compute engine, then streams them out with a fixed read latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for tile_start
// LOAD    | accepting ld_data words into the banks, bank 0 first
// COMPUTE | banks owned by the compute engine until comp_done
// STORE   | issuing bank reads while st_ready is high
// DRAIN   | RD_LAT cycles for the last reads to come back
// DONE    | one cycle; st_done and tile_done pulse
module out_fm_tile_ctrl
  import out_fm_tile_ctrl_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int Tn     = 16,
  parameter int Tr     = 64,
  parameter int Tc     = 16,
  parameter int Y      = 4,
  parameter int RD_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tile_start,
  input  logic ld_skip,
  output logic tile_done,
  output logic busy,
  output logic comp_start,
  input  logic comp_done,
  output logic computing_on_going,
  output logic out_fm_ld_start,
  output logic out_fm_ld_done,
  output logic out_fm_st_start,
  output logic out_fm_st_done,
  out_fm_tile_ctrl_if.master bus
);

  localparam int CAP = cap_words(Tn, Tr, Tc, Y);
  localparam int BW  = bank_w(Y);
  localparam int DCW = bank_w(RD_LAT);

  state_e        state;
  logic [BW-1:0] bank_idx;
  logic [DCW-1:0] drain_cnt;
  logic [AW-1:0] word_cnt;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          word_wrap;
  logic          last_bank;
  logic          ld_accept;
  logic          rd_issue;
  logic [Y-1:0]  bank_onehot;
  logic [DW-1:0] wr_word;
  logic [RD_LAT-1:0] vld_pipe;
  logic [BW-1:0] bank_pipe [RD_LAT];

  assign ld_accept   = (state == S_LOAD) && bus.ld_valid;
  assign rd_issue    = (state == S_STORE) && bus.st_ready;
  assign cnt_inc     = ld_accept || rd_issue;
  // Holding the counter clear outside LOAD/STORE guarantees a zero start on every phase entry.
  assign cnt_clr     = !((state == S_LOAD) || (state == S_STORE));
  assign word_wrap   = cnt_inc && (word_cnt == AW'(CAP - 1));
  assign last_bank   = (bank_idx == BW'(Y - 1));
  assign bank_onehot = Y'(1) << bank_idx;

  assign wr_word            = bus.ld_data;
  assign bus.wr_data        = wr_word;
  assign bus.ld_ready       = (state == S_LOAD);
  assign bus.wr_ena         = ld_accept ? bank_onehot : '0;
  assign bus.rd_ena         = rd_issue ? bank_onehot : '0;
  assign bus.st_valid       = vld_pipe[RD_LAT-1];
  assign bus.st_bank        = bank_pipe[RD_LAT-1];
  assign busy               = (state != S_IDLE);
  assign computing_on_going = (state == S_COMPUTE);

  out_fm_tile_ctrl_counter #(
    .CW  (AW),
    .MAX (CAP - 1)
  ) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (word_cnt)
  );

  // Tile sequencing with registered phase pulses and bank index tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      bank_idx        <= '0;
      drain_cnt       <= '0;
      comp_start      <= 1'b0;
      out_fm_ld_start <= 1'b0;
      out_fm_ld_done  <= 1'b0;
      out_fm_st_start <= 1'b0;
      out_fm_st_done  <= 1'b0;
      tile_done       <= 1'b0;
    end else begin
      comp_start      <= 1'b0;
      out_fm_ld_start <= 1'b0;
      out_fm_ld_done  <= 1'b0;
      out_fm_st_start <= 1'b0;
      out_fm_st_done  <= 1'b0;
      tile_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tile_start) begin
            bank_idx <= '0;
            if (ld_skip) begin
              state      <= S_COMPUTE;
              comp_start <= 1'b1;
            end else begin
              state           <= S_LOAD;
              out_fm_ld_start <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (word_wrap) begin
            if (last_bank) begin
              bank_idx       <= '0;
              state          <= S_COMPUTE;
              out_fm_ld_done <= 1'b1;
              comp_start     <= 1'b1;
            end else begin
              bank_idx <= bank_idx + BW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (comp_done) begin
            bank_idx        <= '0;
            state           <= S_STORE;
            out_fm_st_start <= 1'b1;
          end
        end
        S_STORE: begin
          if (word_wrap) begin
            if (last_bank) begin
              bank_idx  <= '0;
              drain_cnt <= DCW'(RD_LAT - 1);
              state     <= S_DRAIN;
            end else begin
              bank_idx <= bank_idx + BW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state          <= S_DONE;
            out_fm_st_done <= 1'b1;
            tile_done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Read-latency delay line: issue flag and its bank, RD_LAT cycles deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) bank_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= rd_issue;
      bank_pipe[0] <= rd_issue ? bank_idx : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        bank_pipe[i] <= bank_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_out_fm_tile_ctrl.sv
// Directed bench for out_fm_tile_ctrl with Tn=4, Tr=2, Tc=2, Y=2, RD_LAT=3
// (8 words per bank, 16 words per tile).
module tb_out_fm_tile_ctrl;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TN = 4;
  localparam int TR = 2;
  localparam int TC = 2;
  localparam int Y  = 2;
  localparam int RL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tile_start = 1'b0;
  logic ld_skip = 1'b0;
  logic comp_done = 1'b0;
  logic tile_done, busy, comp_start, computing_on_going;
  logic out_fm_ld_start, out_fm_ld_done, out_fm_st_start, out_fm_st_done;

  always #5 clk = ~clk;

  out_fm_tile_ctrl_if #(.DW(DW), .Y(Y)) bus ();

  out_fm_tile_ctrl #(
    .AW(AW), .DW(DW), .Tn(TN), .Tr(TR), .Tc(TC), .Y(Y), .RD_LAT(RL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .tile_start         (tile_start),
    .ld_skip            (ld_skip),
    .tile_done          (tile_done),
    .busy               (busy),
    .comp_start         (comp_start),
    .comp_done          (comp_done),
    .computing_on_going (computing_on_going),
    .out_fm_ld_start    (out_fm_ld_start),
    .out_fm_ld_done     (out_fm_ld_done),
    .out_fm_st_start    (out_fm_st_start),
    .out_fm_st_done     (out_fm_st_done),
    .bus                (bus)
  );

  typedef struct {
    logic          rst;
    logic          tile_start;
    logic          ld_skip;
    logic          ld_valid;
    logic          st_ready;
    logic          comp_done;
    logic [DW-1:0] ld_data;
    logic [14:0]   exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // flags: busy ld_ready wr_ena[1:0] rd_ena[1:0] st_valid st_bank comp_start
  //        computing ld_start ld_done st_start st_done tile_done
  function automatic logic [14:0] fl(input logic b, input logic ldr,
                                     input logic [1:0] wr, input logic [1:0] rd,
                                     input logic sv, input logic sb, input logic cs,
                                     input logic co, input logic lds, input logic ldd,
                                     input logic sts, input logic std, input logic td);
    return {b, ldr, wr, rd, sv, sb, cs, co, lds, ldd, sts, std, td};
  endfunction

  function automatic logic [14:0] act_flags();
    return {busy, bus.ld_ready, bus.wr_ena, bus.rd_ena, bus.st_valid, bus.st_bank,
            comp_start, computing_on_going, out_fm_ld_start, out_fm_ld_done,
            out_fm_st_start, out_fm_st_done, tile_done};
  endfunction

  task automatic add(input logic r, input logic ts, input logic sk, input logic lv,
                     input logic [DW-1:0] ld, input logic sr, input logic cd,
                     input logic [14:0] e);
    vec_t v;
    v.rst = r; v.tile_start = ts; v.ld_skip = sk; v.ld_valid = lv;
    v.ld_data = ld; v.st_ready = sr; v.comp_done = cd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int acc, last_acc, issued, nvalid, last_iss, exp_c;
  logic got_done, got_td, exp_b;
  logic [1:0] exp_wr, exp_rd;
  int iq[$];
  logic bq[$];

  initial begin
    bus.ld_data  = '0;
    bus.ld_valid = 1'b0;
    bus.st_ready = 1'b0;

    // Vector table: reset, steady-load tile, skip tile, reset mid-STORE.
    add(1, 1, 0, 1, 32'h55, 0, 0, '0);
    add(0, 0, 0, 0, 0, 0, 1, '0);
    add(0, 1, 0, 0, 0, 0, 0, '0);
    for (int k = 0; k < 16; k++)
      add(0, 0, 0, 1, DW'(k), 0, 0,
          fl(1, 1, (k < 8) ? 2'b01 : 2'b10, 2'b00, 0, 0, 0, 0, (k == 0), 0, 0, 0, 0));
    add(0, 0, 0, 1, 32'hDEAD, 0, 0, fl(1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, fl(1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, fl(1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++)
      add(0, 0, 0, 0, 0, 1, 0,
          fl(1, 0, 2'b00, (k < 8) ? 2'b01 : 2'b10, (k >= 3), ((k - 3) >= 8),
             0, 0, 0, 0, (k == 0), 0, 0));
    for (int d = 0; d < 3; d++)
      add(0, 0, 0, 0, 0, 1, 0, fl(1, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, fl(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 0, 0, 0, 0, 0, 0, '0);
    add(0, 1, 1, 1, 32'hAA, 0, 0, '0);
    add(0, 1, 0, 1, 32'hAB, 0, 0, fl(1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, fl(1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 0, 1, 0, fl(1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, (k == 0), 0, 0));
    add(1, 0, 0, 0, 0, 1, 0, '0);
    add(0, 0, 0, 0, 0, 1, 0, '0);
    add(0, 0, 0, 0, 0, 1, 0, '0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst          = vecs[i].rst;
      tile_start   = vecs[i].tile_start;
      ld_skip      = vecs[i].ld_skip;
      comp_done    = vecs[i].comp_done;
      bus.ld_valid = vecs[i].ld_valid;
      bus.ld_data  = vecs[i].ld_data;
      bus.st_ready = vecs[i].st_ready;
      @(negedge clk);
      chk($sformatf("vec%0d flags", i), 32'(act_flags()), 32'(vecs[i].exp));
      if (vecs[i].exp[12:11] != 2'b00)
        chk($sformatf("vec%0d wr_data", i), bus.wr_data, vecs[i].ld_data);
      @(posedge clk); #1;
    end
    rst = 1'b0; tile_start = 1'b0; ld_skip = 1'b0; comp_done = 1'b0;
    bus.ld_valid = 1'b0; bus.st_ready = 1'b0;

    // New tile after the aborted one: ld_valid toggling 1-0.
    tile_start = 1'b1;
    @(negedge clk);
    chk("start idle busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    tile_start = 1'b0;
    acc = 0; last_acc = -10; got_done = 1'b0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      bus.ld_valid = (c % 2 == 0);
      bus.ld_data  = 32'h1000 + DW'(acc);
      @(negedge clk);
      if (out_fm_ld_done) begin
        got_done = 1'b1;
        chk("ld_done timing", 32'(c), 32'(last_acc + 1));
        chk("ld write count", 32'(acc), 32'd16);
        chk("comp_start with ld_done", 32'(comp_start), 32'd1);
        chk("no write after load", 32'(bus.wr_ena), 32'd0);
      end else begin
        exp_wr = bus.ld_valid ? ((acc < 8) ? 2'b01 : 2'b10) : 2'b00;
        chk($sformatf("toggle wr_ena c%0d", c), 32'(bus.wr_ena), 32'(exp_wr));
        if (bus.ld_valid) begin
          chk($sformatf("toggle wr_data c%0d", c), bus.wr_data, 32'h1000 + acc);
          acc++;
          last_acc = c;
        end
      end
      if (!got_done) begin
        @(posedge clk); #1;
      end
    end
    if (!got_done) chk("ld_done timeout", 32'd0, 32'd1);

    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    comp_done = 1'b1;
    @(negedge clk);
    chk("computing in compute", 32'(computing_on_going), 32'd1);
    @(posedge clk); #1;
    comp_done = 1'b0;

    // Store with st_ready low every third cycle.
    issued = 0; nvalid = 0; last_iss = -10; got_td = 1'b0;
    for (int c = 0; c < 80 && !got_td; c++) begin
      bus.st_ready = (c % 3 != 2);
      @(negedge clk);
      exp_rd = (issued < 16 && bus.st_ready) ? ((issued < 8) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("store rd_ena c%0d", c), 32'(bus.rd_ena), 32'(exp_rd));
      chk($sformatf("store st_start c%0d", c), 32'(out_fm_st_start), 32'(c == 0));
      if (exp_rd != 2'b00) begin
        iq.push_back(c);
        bq.push_back(issued >= 8);
        issued++;
        last_iss = c;
      end
      if (bus.st_valid) begin
        nvalid++;
        if (iq.size() == 0) begin
          chk($sformatf("spurious st_valid c%0d", c), 32'd1, 32'd0);
        end else begin
          exp_c = iq.pop_front();
          exp_b = bq.pop_front();
          chk($sformatf("st_valid latency c%0d", c), 32'(c), 32'(exp_c + RL));
          chk($sformatf("st_bank c%0d", c), 32'(bus.st_bank), 32'(exp_b));
        end
      end
      if (tile_done) begin
        got_td = 1'b1;
        chk("tile_done timing", 32'(c), 32'(last_iss + 4));
        chk("st_valid count", 32'(nvalid), 32'd16);
        chk("st_done with tile_done", 32'(out_fm_st_done), 32'd1);
      end
      @(posedge clk); #1;
    end
    if (!got_td) chk("tile_done timeout", 32'd0, 32'd1);
    bus.st_ready = 1'b0;
    @(negedge clk);
    chk("back to idle", 32'(act_flags()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
